// File: rtl/real_add_sched.sv
// real_add_sched: round-robin scheduler sharing one external scaled adder
// (add_out = add_scale1*add_in1 + add_scale2*add_in2) among N requesters.
// Operands are snapshotted at grant. The result is a registered copy of
// add_out taken after a settle window. This block does no real arithmetic.
//
// state  | meaning
// IDLE   | waiting for any request; round-robin pick from ptr
// ISSUE  | operands presented, adder enabled, settle counter loaded
// SETTLE | adder settling; counter runs down, then result is captured
// DONE   | done pulse ends, grant released, op counter bumped
module real_add_sched #(
  parameter int N    = 4,
  parameter int HOLD = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  real           in1_i    [N],
  input  real           in2_i    [N],
  input  real           scale1_i [N],
  input  real           scale2_i [N],
  output logic [N-1:0]  grant_o,
  output logic [N-1:0]  done_o,
  output logic          abort_o,
  output real           result_o,
  output logic          busy_o,
  output logic [15:0]   op_cnt_o,
  output logic          add_en,
  output real           add_in1,
  output real           add_in2,
  output real           add_scale1,
  output real           add_scale2,
  input  real           add_out
);

  localparam int IW = $clog2(N);

  typedef enum logic [1:0] {IDLE, ISSUE, SETTLE, DONE} state_t;

  state_t          state_q;
  logic [IW-1:0]   ptr_q;
  logic [IW-1:0]   gidx_q;
  logic [3:0]      cnt_q;
  logic [N-1:0]    grant_q;
  logic [N-1:0]    done_q;
  logic            abort_q;
  logic [15:0]     op_cnt_q;
  real             result_q;
  real             add_in1_q;
  real             add_in2_q;
  real             add_scale1_q;
  real             add_scale2_q;

  logic [IW-1:0]   win_d;
  logic            win_vld_d;
  logic [IW-1:0]   ptr_nxt_d;

  // Round-robin search: scan from farthest to nearest so the first set bit
  // at or after ptr (wrapping) is the last one written.
  always_comb begin
    win_d     = '0;
    win_vld_d = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr_q) + k) % N]) begin
        win_d     = IW'((int'(ptr_q) + k) % N);
        win_vld_d = 1'b1;
      end
    end
  end

  // Pointer moves past the granted requester, wrapping at N-1.
  always_comb begin
    ptr_nxt_d = (gidx_q == IW'(N - 1)) ? '0 : gidx_q + 1'b1;
  end

  // Scheduler FSM with all outputs registered. The settle counter is loaded
  // with HOLD, so capture lands HOLD+2 edges after the grant edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      gidx_q       <= '0;
      cnt_q        <= '0;
      grant_q      <= '0;
      done_q       <= '0;
      abort_q      <= 1'b0;
      op_cnt_q     <= '0;
      result_q     <= 0.0;
      add_in1_q    <= 0.0;
      add_in2_q    <= 0.0;
      add_scale1_q <= 0.0;
      add_scale2_q <= 0.0;
    end else begin
      abort_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (win_vld_d) begin
            gidx_q       <= win_d;
            grant_q      <= {{(N-1){1'b0}}, 1'b1} << win_d;
            add_in1_q    <= in1_i[win_d];
            add_in2_q    <= in2_i[win_d];
            add_scale1_q <= scale1_i[win_d];
            add_scale2_q <= scale2_i[win_d];
            state_q      <= ISSUE;
          end
        end
        ISSUE: begin
          if (!req[gidx_q]) begin
            grant_q <= '0;
            abort_q <= 1'b1;
            ptr_q   <= ptr_nxt_d;
            state_q <= IDLE;
          end else begin
            cnt_q   <= 4'(HOLD);
            state_q <= SETTLE;
          end
        end
        SETTLE: begin
          // a dropped request wins over capture on the same edge
          if (!req[gidx_q]) begin
            grant_q <= '0;
            abort_q <= 1'b1;
            ptr_q   <= ptr_nxt_d;
            state_q <= IDLE;
          end else if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            result_q <= add_out;
            done_q   <= grant_q;
            state_q  <= DONE;
          end
        end
        DONE: begin
          done_q   <= '0;
          grant_q  <= '0;
          op_cnt_q <= op_cnt_q + 16'd1;
          ptr_q    <= ptr_nxt_d;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant_o    = grant_q;
  assign done_o     = done_q;
  assign abort_o    = abort_q;
  assign result_o   = result_q;
  assign op_cnt_o   = op_cnt_q;
  assign busy_o     = (state_q != IDLE);
  assign add_en     = (state_q == ISSUE) || (state_q == SETTLE);
  assign add_in1    = add_in1_q;
  assign add_in2    = add_in2_q;
  assign add_scale1 = add_scale1_q;
  assign add_scale2 = add_scale2_q;

endmodule
